lcrc_32_gen: RTL and testbench

//  Running 32-bit link CRC (LCRC) generator for the replay-buffer TX path.
//  - Absorbs one WIDTH-bit data word per clock into a CRC-32 accumulator.
//  - Each clock, outputs the current word concatenated with the LCRC of all

---
 rtl/lcrc_32_gen_if.sv | 10 +
 rtl/lcrc_32_gen.sv | 42 ++++
 tb/tb_lcrc_32_gen.sv | 99 +++++++++
 3 files changed

// File: rtl/lcrc_32_gen_if.sv
// Data path bundle for the LCRC generator: one word in, {word, LCRC} out.
interface lcrc_32_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]    in;
  logic [WIDTH+31:0]   final_out;

  modport master (output in, input final_out);
  modport slave (input in, output final_out);
endinterface

// File: rtl/lcrc_32_gen.sv
// Running reflected CRC-32 link CRC: absorbs one WIDTH-bit word per clock and
// registers the word alongside the complemented CRC of everything since reset.
module lcrc_32_gen #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  lcrc_32_gen_if.slave bus
);

  localparam logic [31:0] Poly = 32'hEDB88320;
  localparam logic [31:0] Seed = 32'hFFFFFFFF;

  // Declaration initialisers give a defined power-up state without a reset.
  logic [31:0]       crc_q = Seed;
  logic [31:0]       crc_d;
  logic [WIDTH+31:0] final_q = '0;
  logic [WIDTH-1:0]  data;

  // LSB-first bit-serial update, fully unrolled into one cycle.
  always_comb begin
    crc_d = crc_q;
    data  = bus.in;
    for (int i = 0; i < WIDTH; i++) begin
      crc_d = {1'b0, crc_d[31:1]} ^ ({32{crc_d[0] ^ data[0]}} & Poly);
      data  = data >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q   <= Seed;
      final_q <= '0;
    end else begin
      crc_q   <= crc_d;
      final_q <= {bus.in, ~crc_d};
    end
  end

  assign bus.final_out = final_q;

endmodule

// File: tb/tb_lcrc_32_gen.sv
// Self-checking bench for lcrc_32_gen using a table-driven CRC-32 reference.
module tb_lcrc_32_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lcrc_32_gen_if #(.WIDTH(8)) bus ();

  lcrc_32_gen #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] tbl [256];
  logic [7:0]  frame [$];
  logic [39:0] exp_q = '0;

  function automatic logic [31:0] crc_of(input logic [7:0] q [$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[k]) c = tbl[(c[7:0] ^ q[k])] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Apply one edge, advance the frame model and compare against it.
  task automatic step(input logic rst, input logic [7:0] d, input string tag);
    reset  = rst;
    bus.in = d;
    @(posedge clk);
    #1;
    if (rst) begin
      frame.delete();
      exp_q = '0;
    end else begin
      frame.push_back(d);
      exp_q = {d, crc_of(frame)};
    end
    check(tag, bus.final_out, exp_q);
  endtask

  initial begin
    logic [31:0] c;
    logic [7:0]  s [9];
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[n] = c;
    end
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    bus.in = 8'h55;
    #1;
    check("powerup", bus.final_out, 40'h0);

    for (int n = 0; n < 50; n++) step(1'b0, 8'h55, "const55");

    step(1'b1, 8'hFF, "reset0");
    step(1'b1, 8'hFF, "reset1");
    check("reset_const", bus.final_out, 40'h0);
    step(1'b0, 8'h00, "byte00");
    check("byte00_const", bus.final_out, {8'h00, 32'hD202EF8D});

    step(1'b1, 8'h00, "rst_a");
    step(1'b0, 8'h61, "byte61");
    check("byte61_const", bus.final_out, {8'h61, 32'hE8B7BE43});

    step(1'b1, 8'h00, "rst_str");
    foreach (s[k]) step(1'b0, s[k], "str");
    check("check_string", bus.final_out, {8'h39, 32'hCBF43926});

    step(1'b1, 8'h00, "rst_mid");
    step(1'b0, 8'h31, "mid_pre0");
    step(1'b0, 8'h32, "mid_pre1");
    step(1'b1, 8'hA5, "mid_rst");
    foreach (s[k]) step(1'b0, s[k], "mid_str");
    check("mid_reset_string", bus.final_out, {8'h39, 32'hCBF43926});

    for (int n = 0; n < 1000; n++)
      step(($urandom_range(0, 19) == 0), 8'($urandom), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
